gift_effect_ctrl: RTL and testbench
===================================

Name: gift_effect_ctrl

Overview:
- Downstream consumer of the gift controller.
- Takes a "gift caught" event plus its 3-bit kind and turns it into persistent game-state effects: paddle width level, ball speed level, hidden-ball and shooting timers, and one-shot drop/multiball requests.
- Sits between gift control and the paddle/ball/render logic.
- Ball loss (lost) clears every effect.

Parameters:
- PD_BASE, 40, paddle width in pixels at width level 0.
- PD_STEP, 8, pixels added per width level.
- HID_FRAMES, 300, frame ticks the hidden effect lasts.
- SOT_FRAMES, 600, frame ticks the shooting effect lasts.
- TMR_W, 10, timer counter width; must hold max(HID_FRAMES, SOT_FRAMES).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- catch  input  1  one-cycle pulse: paddle caught the active gift.
- kind  input  3  gift kind, valid with catch: 000 INC, 001 DEC, 010 SPU, 011 SPD, 100 HID, 101 SOT, 110 DRP, 111 MUL.
- lost  input  1  level/pulse: ball lost; clear all effects.
- frame_tick  input  1  one-cycle pulse once per video frame.
- ready  output  1  1 when the one-entry pending buffer is empty.
- pd_size  output  10  paddle width in pixels = PD_BASE + PD_STEP*width_lvl.
- speed_lvl  output  2  ball speed level 0..3.
- hidden  output  1  ball-hidden effect active.
- shoot  output  1  paddle shooting effect active.
- drop_req  output  1  one-cycle pulse: drop extra gifts.
- multi_req  output  1  one-cycle pulse: spawn extra balls.
- gift_count  output  8  applied-gift statistic (see Optional Feature).

Behaviour:
- Reset (async, reset=0):
  - width_lvl=2, so pd_size=PD_BASE+2*PD_STEP (56 with defaults).
  - speed_lvl=1; hidden=0; shoot=0; drop_req=0; multi_req=0; gift_count=0; ready=1.
  - Both timers 0; pending buffer empty; FSM in IDLE.
- FSM states: IDLE, LATCH, APPLY.
  - IDLE: on catch, capture kind into the pending buffer; ready=0 next cycle; go to LATCH.
  - LATCH: decode kind into a one-hot effect vector (registered); go to APPLY.
  - APPLY: update state per the kind rules below; clear the buffer; ready=1 next cycle; return to IDLE.
- Latency: catch at cycle N. The effect is visible on outputs at cycle N+3 (outputs registered after APPLY at N+2). A drop/multi pulse is high for exactly cycle N+3.
- catch while ready=0: ignored; no queueing beyond the single buffer.
- Kind rules:
  - INC: width_lvl+1, saturate at 4.
  - DEC: width_lvl-1, saturate at 0.
  - SPU: speed_lvl+1, saturate at 3.
  - SPD: speed_lvl-1, saturate at 0.
  - HID: timer_h=HID_FRAMES; hidden=1. Reloads to full if already active.
  - SOT: timer_s=SOT_FRAMES; shoot=1. Reloads to full if already active.
  - DRP: drop_req pulse. MUL: multi_req pulse. No other state change for either.
- Timers:
  - On frame_tick, each nonzero timer decrements by 1.
  - hidden = (timer_h != 0); shoot = (timer_s != 0), both registered. The effect drops the cycle after the timer reaches 0.
  - Reload in APPLY and frame_tick in the same cycle: the reload wins; no decrement that cycle.
- pd_size arithmetic: unsigned 10-bit. Parameters must satisfy PD_BASE+4*PD_STEP < 1024; no wrap handling.
- lost=1 (synchronous, highest priority):
  - Next edge: width_lvl=2, speed_lvl=1, timers=0, hidden=0, shoot=0.
  - Pending buffer cleared; FSM to IDLE; suppresses any APPLY and any pulse that cycle.
  - catch in the same cycle as lost is dropped. gift_count is not cleared.
- Reset mid-operation: all state returns to reset values immediately; no pulse is emitted.

Optional Feature:
- Macro GIFT_STATS_EN.
- When defined: gift_count increments by 1 in every APPLY that is not suppressed by lost, saturating at 255.
- When undefined: gift_count is tied to 8'd0 and no counter logic is synthesised.
- Port list identical in both builds.

Test Plan:
- Reset release, no stimulus -> pd_size=56, speed_lvl=1, hidden=0, shoot=0, ready=1, no pulses.
- Three INC catches spaced 4 cycles apart -> pd_size 64, then 72, then 72 (saturated at level 4). Each change appears 3 cycles after its catch.
- catch kind=100, then 300 frame_ticks -> hidden=1 from catch+3 through the 300th tick, then 0. Second HID catch at tick 150 -> hidden lasts until tick 450.
- catch kind=110 and, one cycle later, catch kind=111 -> drop_req high exactly 1 cycle at N+3; second catch ignored (ready=0); multi_req never asserts.
- SPU x3 then lost=1 for 1 cycle with a simultaneous catch -> speed_lvl 3, then back to 1; pd_size=56; the concurrent catch has no effect.
- With GIFT_STATS_EN: 260 applied catches -> gift_count=255. Without the macro -> gift_count=0 throughout.

Source files
------------

// File: rtl/gift_effect_ctrl.sv
// Gift effect controller: turns caught-gift events into paddle/ball game-state effects.
// Optional build macro GIFT_STATS_EN enables the saturating applied-gift counter (gift_count).
//
// state | meaning
// IDLE  | buffer empty, ready for a catch
// LATCH | kind captured, decoding into one-hot effect vector
// APPLY | effect vector applied to game state, buffer released
module gift_effect_ctrl #(
    parameter int PD_BASE    = 40,
    parameter int PD_STEP    = 8,
    parameter int HID_FRAMES = 300,
    parameter int SOT_FRAMES = 600,
    parameter int TMR_W      = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       catch,
    input  logic [2:0] kind,
    input  logic       lost,
    input  logic       frame_tick,
    output logic       ready,
    output logic [9:0] pd_size,
    output logic [1:0] speed_lvl,
    output logic       hidden,
    output logic       shoot,
    output logic       drop_req,
    output logic       multi_req,
    output logic [7:0] gift_count
);

    typedef enum logic [1:0] {IDLE, LATCH, APPLY} state_t;

    state_t             state, state_nxt;
    logic [2:0]         kind_buf;
    logic [7:0]         eff;
    logic [2:0]         width_lvl;
    logic [TMR_W-1:0]   timer_h, timer_s, timer_h_nxt, timer_s_nxt;
    logic               apply_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (catch) state_nxt = LATCH;
            LATCH:   state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (lost) state_nxt = IDLE;
    end

    assign ready    = (state == IDLE);
    assign apply_en = (state == APPLY) && !lost;
    assign pd_size  = 10'(PD_BASE) + 10'(PD_STEP) * 10'(width_lvl);

    // eff bit index equals the gift kind code (INC=0 ... MUL=7)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            kind_buf <= 3'd0;
            eff      <= 8'd0;
        end else if (lost) begin
            kind_buf <= 3'd0;
            eff      <= 8'd0;
        end else begin
            if (state == IDLE && catch) kind_buf <= kind;
            if (state == LATCH)         eff <= 8'd1 << kind_buf;
            else if (state == APPLY)    eff <= 8'd0;
        end
    end

    // Reload takes precedence over a coincident frame tick.
    always_comb begin
        timer_h_nxt = timer_h;
        timer_s_nxt = timer_s;
        if (lost) begin
            timer_h_nxt = '0;
            timer_s_nxt = '0;
        end else begin
            if (apply_en && eff[4])                 timer_h_nxt = TMR_W'(HID_FRAMES);
            else if (frame_tick && timer_h != '0)   timer_h_nxt = timer_h - TMR_W'(1);
            if (apply_en && eff[5])                 timer_s_nxt = TMR_W'(SOT_FRAMES);
            else if (frame_tick && timer_s != '0)   timer_s_nxt = timer_s - TMR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            width_lvl <= 3'd2;
            speed_lvl <= 2'd1;
            timer_h   <= '0;
            timer_s   <= '0;
            hidden    <= 1'b0;
            shoot     <= 1'b0;
            drop_req  <= 1'b0;
            multi_req <= 1'b0;
        end else begin
            timer_h   <= timer_h_nxt;
            timer_s   <= timer_s_nxt;
            hidden    <= (timer_h_nxt != '0);
            shoot     <= (timer_s_nxt != '0);
            drop_req  <= apply_en && eff[6];
            multi_req <= apply_en && eff[7];
            if (lost) begin
                width_lvl <= 3'd2;
                speed_lvl <= 2'd1;
            end else if (apply_en) begin
                if (eff[0] && width_lvl != 3'd4)  width_lvl <= width_lvl + 3'd1;
                if (eff[1] && width_lvl != 3'd0)  width_lvl <= width_lvl - 3'd1;
                if (eff[2] && speed_lvl != 2'd3)  speed_lvl <= speed_lvl + 2'd1;
                if (eff[3] && speed_lvl != 2'd0)  speed_lvl <= speed_lvl - 2'd1;
            end
        end
    end

`ifdef GIFT_STATS_EN
    logic [7:0] gift_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                            gift_cnt <= 8'd0;
        else if (apply_en && gift_cnt != 8'hFF) gift_cnt <= gift_cnt + 8'd1;
    end

    assign gift_count = gift_cnt;
`else
    assign gift_count = 8'd0;
`endif

endmodule

// File: tb/tb_gift_effect_ctrl.sv
// Directed bench for gift_effect_ctrl: vector table for kind rules plus
// hand sequences for timers, busy-drop, lost and mid-operation reset.
module tb_gift_effect_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       catch = 1'b0;
    logic [2:0] kind = 3'd0;
    logic       lost = 1'b0;
    logic       frame_tick = 1'b0;
    logic       ready;
    logic [9:0] pd_size;
    logic [1:0] speed_lvl;
    logic       hidden, shoot, drop_req, multi_req;
    logic [7:0] gift_count;

    int n_vec = 0;
    int n_err = 0;

    gift_effect_ctrl dut (
        .clock(clock), .reset(reset), .catch(catch), .kind(kind), .lost(lost),
        .frame_tick(frame_tick), .ready(ready), .pd_size(pd_size),
        .speed_lvl(speed_lvl), .hidden(hidden), .shoot(shoot),
        .drop_req(drop_req), .multi_req(multi_req), .gift_count(gift_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] k;
        int         pd;
        int         spd;
        logic       drp;
        logic       mul;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Leaves the bench at the N+3 sample point of the catch.
    task automatic do_catch(input logic [2:0] k);
        kind  = k;
        catch = 1'b1;
        step(1);
        catch = 1'b0;
        step(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    initial begin
        int prev_pd;
        int multi_seen;

        tbl[0]  = '{3'd0, 64, 1, 1'b0, 1'b0};
        tbl[1]  = '{3'd0, 72, 1, 1'b0, 1'b0};
        tbl[2]  = '{3'd0, 72, 1, 1'b0, 1'b0};
        tbl[3]  = '{3'd1, 64, 1, 1'b0, 1'b0};
        tbl[4]  = '{3'd1, 56, 1, 1'b0, 1'b0};
        tbl[5]  = '{3'd1, 48, 1, 1'b0, 1'b0};
        tbl[6]  = '{3'd1, 40, 1, 1'b0, 1'b0};
        tbl[7]  = '{3'd1, 40, 1, 1'b0, 1'b0};
        tbl[8]  = '{3'd2, 40, 2, 1'b0, 1'b0};
        tbl[9]  = '{3'd2, 40, 3, 1'b0, 1'b0};
        tbl[10] = '{3'd2, 40, 3, 1'b0, 1'b0};
        tbl[11] = '{3'd3, 40, 2, 1'b0, 1'b0};
        tbl[12] = '{3'd3, 40, 1, 1'b0, 1'b0};
        tbl[13] = '{3'd3, 40, 0, 1'b0, 1'b0};
        tbl[14] = '{3'd3, 40, 0, 1'b0, 1'b0};
        tbl[15] = '{3'd6, 40, 0, 1'b1, 1'b0};
        tbl[16] = '{3'd7, 40, 0, 1'b0, 1'b1};
        tbl[17] = '{3'd0, 48, 0, 1'b0, 1'b0};

        step(2);
        reset = 1'b1;
        step(2);
        chk("rst_pd", pd_size, 56);
        chk("rst_spd", speed_lvl, 1);
        chk("rst_hidden", hidden, 0);
        chk("rst_shoot", shoot, 0);
        chk("rst_ready", ready, 1);
        chk("rst_drop", drop_req, 0);
        chk("rst_multi", multi_req, 0);
        chk("rst_count", gift_count, 0);

        prev_pd = 56;
        for (int i = 0; i < 18; i++) begin
            kind  = tbl[i].k;
            catch = 1'b1;
            step(1);
            catch = 1'b0;
            chk("busy_ready", ready, 0);
            step(1);
            chk("early_pd", pd_size, prev_pd);
            chk("early_drop", drop_req, 0);
            step(1);
            chk("vec_pd", pd_size, tbl[i].pd);
            chk("vec_spd", speed_lvl, tbl[i].spd);
            chk("vec_drop", drop_req, tbl[i].drp);
            chk("vec_multi", multi_req, tbl[i].mul);
            chk("vec_ready", ready, 1);
            prev_pd = tbl[i].pd;
            step(1);
            chk("pulse_end_drop", drop_req, 0);
            chk("pulse_end_multi", multi_req, 0);
        end

        // DRP then MUL one cycle later: second catch must be ignored.
        do_reset();
        kind = 3'd6; catch = 1'b1;
        step(1);
        kind = 3'd7;
        step(1);
        catch = 1'b0;
        multi_seen = 0;
        chk("drp_early", drop_req, 0);
        step(1);
        chk("drp_pulse", drop_req, 1);
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (multi_req) multi_seen++;
            if (c == 0) chk("drp_one_cycle", drop_req, 0);
        end
        chk("mul_ignored", multi_seen, 0);

        // Hidden timer, reload at tick 150 with a coincident tick in APPLY.
        do_catch(3'd4);
        chk("hid_on", hidden, 1);
        ticks(150);
        chk("hid_mid", hidden, 1);
        kind = 3'd4; catch = 1'b1;
        step(1);
        catch = 1'b0;
        step(1);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        chk("hid_reload", hidden, 1);
        ticks(299);
        chk("hid_last", hidden, 1);
        ticks(1);
        chk("hid_off", hidden, 0);

        // Shooting timer.
        do_catch(3'd5);
        chk("sot_on", shoot, 1);
        ticks(599);
        chk("sot_last", shoot, 1);
        ticks(1);
        chk("sot_off", shoot, 0);

        // SPU x3 plus active effects, then lost with a simultaneous catch.
        do_catch(3'd2);
        do_catch(3'd2);
        do_catch(3'd2);
        chk("spu_sat", speed_lvl, 3);
        do_catch(3'd0);
        do_catch(3'd4);
        do_catch(3'd5);
        chk("pre_lost_pd", pd_size, 64);
        kind = 3'd0; catch = 1'b1; lost = 1'b1;
        step(1);
        catch = 1'b0; lost = 1'b0;
        chk("lost_spd", speed_lvl, 1);
        chk("lost_pd", pd_size, 56);
        chk("lost_hidden", hidden, 0);
        chk("lost_shoot", shoot, 0);
        chk("lost_ready", ready, 1);
        step(4);
        chk("lost_catch_dropped", pd_size, 56);

        // lost during APPLY suppresses the pulse.
        kind = 3'd6; catch = 1'b1;
        step(1);
        catch = 1'b0;
        step(1);
        lost = 1'b1;
        step(1);
        lost = 1'b0;
        chk("lost_apply_drop", drop_req, 0);
        chk("lost_apply_ready", ready, 1);

        // Asynchronous reset mid-operation.
        do_catch(3'd1);
        kind = 3'd6; catch = 1'b1;
        step(1);
        catch = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_ready", ready, 1);
        chk("async_pd", pd_size, 56);
        step(1);
        reset = 1'b1;
        step(1);
        chk("async_no_drop", drop_req, 0);
        step(2);
        chk("async_no_drop_late", drop_req, 0);

        repeat (260) do_catch(3'd6);
`ifdef GIFT_STATS_EN
        chk("count_sat", gift_count, 255);
`else
        chk("count_zero", gift_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
